// File: rtl/mvm_result_collector.sv
// Collects the four MVM row results, adds a saturating per-row bias, then streams the vector out.
// Optional MVM_COLLECTOR_STATS_EN adds saturation and dropped-strobe counters.
module mvm_result_collector #(
   parameter int unsigned OUTPUT_WIDTH = 16,
   parameter int unsigned ROWS         = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_in,
   input  logic [OUTPUT_WIDTH-1:0] row_data_1,
   input  logic [OUTPUT_WIDTH-1:0] row_data_2,
   input  logic [OUTPUT_WIDTH-1:0] row_data_3,
   input  logic [OUTPUT_WIDTH-1:0] row_data_4,
   input  logic [ROWS-1:0]         row_done,
   input  logic [OUTPUT_WIDTH-1:0] bias_1,
   input  logic [OUTPUT_WIDTH-1:0] bias_2,
   input  logic [OUTPUT_WIDTH-1:0] bias_3,
   input  logic [OUTPUT_WIDTH-1:0] bias_4,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUTPUT_WIDTH-1:0] out_data,
   output logic [1:0]              out_idx,
   output logic                    vec_done,
   output logic                    busy
`ifdef MVM_COLLECTOR_STATS_EN
   ,
   output logic [7:0]              sat_count,
   output logic [7:0]              drop_count
`endif
);

   localparam int unsigned W     = OUTPUT_WIDTH;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned INC_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
   localparam logic [W-1:0]     POS_MAX  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]     NEG_MIN  = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_EMIT    = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             start_q;
   logic [ROWS-1:0]  row_done_q;
   logic [ROWS-1:0]  flag_q, flag_d;
   logic [W-1:0]     slot_q [ROWS];
   logic [W-1:0]     slot_d [ROWS];
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             out_valid_q;
   logic [W-1:0]     out_data_q;
   logic [IDX_W-1:0] out_idx_q;
   logic             vec_done_q, vec_done_d;
   logic             busy_q;

   logic             start_rise;
   logic [ROWS-1:0]  done_rise;
   logic [ROWS-1:0]  cap_mask;
   logic [ROWS-1:0]  drop_mask;
   logic [W-1:0]     data_a [ROWS];
   logic [W-1:0]     bias_a [ROWS];
   logic [W-1:0]     sat_val [ROWS];
   logic [ROWS-1:0]  sat_hit;

   assign data_a[0] = row_data_1;
   assign data_a[1] = row_data_2;
   assign data_a[2] = row_data_3;
   assign data_a[3] = row_data_4;
   assign bias_a[0] = bias_1;
   assign bias_a[1] = bias_2;
   assign bias_a[2] = bias_3;
   assign bias_a[3] = bias_4;

   assign start_rise = start_in & ~start_q;
   assign done_rise  = row_done & ~row_done_q;

   // Signed add one bit wider, clamp when the sign of the wide sum disagrees with the narrow sum
   always_comb begin : p_sat_add
      logic [W:0] sum;
      sum = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         sum = {data_a[i][W-1], data_a[i]} + {bias_a[i][W-1], bias_a[i]};
         sat_hit[i] = sum[W] ^ sum[W-1];
         if (sat_hit[i]) begin
            sat_val[i] = sum[W] ? NEG_MIN : POS_MAX;
         end else begin
            sat_val[i] = sum[W-1:0];
         end
      end
   end

   // Next-state, capture and emit control
   always_comb begin
      state_d    = state_q;
      flag_d     = flag_q;
      idx_d      = idx_q;
      vec_done_d = 1'b0;
      cap_mask   = '0;
      drop_mask  = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         slot_d[i] = slot_q[i];
      end

      unique case (state_q)
         S_IDLE: begin
            drop_mask = done_rise;
            if (start_rise) begin
               flag_d  = '0;
               idx_d   = '0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (!start_in) begin
               flag_d  = '0;
               state_d = S_IDLE;
            end else begin
               cap_mask  = done_rise & ~flag_q;
               drop_mask = done_rise & flag_q;
               for (int unsigned i = 0; i < ROWS; i++) begin
                  if (cap_mask[i]) begin
                     slot_d[i] = sat_val[i];
                  end
               end
               flag_d = flag_q | cap_mask;
               if (&flag_d) begin
                  idx_d   = '0;
                  state_d = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            drop_mask = done_rise;
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  flag_d     = '0;
                  vec_done_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            flag_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         row_done_q <= '0;
         flag_q     <= '0;
         idx_q      <= '0;
         for (int unsigned i = 0; i < ROWS; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         start_q    <= start_in;
         row_done_q <= row_done;
         flag_q     <= flag_d;
         idx_q      <= idx_d;
         for (int unsigned i = 0; i < ROWS; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   // Outputs are registered from next-state so out_valid rises the cycle after the final capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         vec_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         out_valid_q <= (state_d == S_EMIT);
         out_data_q  <= (state_d == S_EMIT) ? slot_d[idx_d] : '0;
         out_idx_q   <= (state_d == S_EMIT) ? idx_d : '0;
         vec_done_q  <= vec_done_d;
         busy_q      <= (state_d != S_IDLE);
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign vec_done  = vec_done_q;
   assign busy      = busy_q;

`ifdef MVM_COLLECTOR_STATS_EN
   logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Per-cycle event counts, added with clamping at all-ones
   always_comb begin : p_stats
      logic [INC_W-1:0] sat_inc;
      logic [INC_W-1:0] drop_inc;
      logic [CNT_W:0]   sat_sum;
      logic [CNT_W:0]   drop_sum;
      sat_inc  = '0;
      drop_inc = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         sat_inc  = sat_inc + INC_W'(cap_mask[i] & sat_hit[i]);
         drop_inc = drop_inc + INC_W'(drop_mask[i]);
      end
      sat_sum    = {1'b0, sat_cnt_q} + (CNT_W+1)'(sat_inc);
      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
      sat_cnt_d  = sat_sum[CNT_W] ? {CNT_W{1'b1}} : sat_sum[CNT_W-1:0];
      drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         sat_cnt_q  <= sat_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign sat_count  = sat_cnt_q;
   assign drop_count = drop_cnt_q;
`else
   logic stats_unused;
   assign stats_unused = ^{drop_mask, sat_hit};
`endif

endmodule
